// File: rtl/cpu_bus_pkg.sv
// Shared bus-select constants and the grant FSM state encoding.
// Combinational only; no latency, no flow control.
package cpu_bus_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request scanning from ptr+1 upward, wrapping; zero latency.
// Purely combinational, no backpressure; also reports any-request and multi-hot.
module rr_priority_pick
  import cpu_bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  always_comb begin
    start = ptr + IDX_W'(1);
    // Rotating the doubled vector puts the highest-priority source at bit 0.
    dbl   = {req, req} >> start;
    rot   = dbl[N_REQ-1:0];
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    idx   = start + off;
    any   = |req;
    multi = (req & (req - N_REQ'(1))) != '0;
  end

endmodule

// File: rtl/encoder_16_to_4_rr.sv
// Registered round-robin 16-to-4 encoder; request->select latency 1 cycle.
// Grant held until grantReady; no new capture in the acceptance cycle (max 1 grant / 2 cycles).
module encoder_16_to_4_rr
  import cpu_bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] encoderInput,
  input  logic             grantReady,
  input  logic             clearError,
  output logic [IDX_W-1:0] encoderOutput,
  output logic             outValid,
  output logic             multiHot,
  output logic             errorSticky
);

  state_t           state_q;
  logic [IDX_W-1:0] enc_q;
  logic [IDX_W-1:0] ptr_q;
  logic             vld_q;
  logic             multi_q;
  logic             sticky_q;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             pick_multi;

  rr_priority_pick u_pick (
    .req   (encoderInput),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .any   (pick_any),
    .multi (pick_multi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      enc_q    <= '0;
      ptr_q    <= IDX_W'(N_REQ - 1);
      vld_q    <= 1'b0;
      multi_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (clearError) sticky_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && pick_any) begin
            enc_q   <= pick_idx;
            multi_q <= pick_multi;
            vld_q   <= 1'b1;
            state_q <= GRANT;
            // A multi-hot capture overrides a simultaneous clear.
            if (pick_multi) sticky_q <= 1'b1;
          end
        end
        GRANT: begin
          if (grantReady) begin
            ptr_q   <= enc_q;
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign encoderOutput = enc_q;
  assign outValid      = vld_q;
  assign multiHot      = multi_q;
  assign errorSticky   = sticky_q;

endmodule

// File: tb/tb_encoder_16_to_4_rr.sv
// Directed bench for encoder_16_to_4_rr: single-hot sweep, round-robin, hold, wrap,
// sticky clear and asynchronous reset mid-grant.
module tb_encoder_16_to_4_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] encoderInput;
  logic        grantReady;
  logic        clearError;
  logic [3:0]  encoderOutput;
  logic        outValid;
  logic        multiHot;
  logic        errorSticky;

  int tests = 0;
  int fails = 0;

  encoder_16_to_4_rr dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .encoderInput  (encoderInput),
    .grantReady    (grantReady),
    .clearError    (clearError),
    .encoderOutput (encoderOutput),
    .outValid      (outValid),
    .multiHot      (multiHot),
    .errorSticky   (errorSticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set beforehand are captured at posedge, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_seq [5] = '{0, 2, 15, 0, 2};
    logic [15:0] onehot;

    reset = 1'b1; enable = 1'b0; encoderInput = '0; grantReady = 1'b0; clearError = 1'b0;
    tick(); tick();
    chk("rst_enc", 16'(encoderOutput), 16'h0);
    chk("rst_vld", 16'(outValid), 16'h0);
    chk("rst_multi", 16'(multiHot), 16'h0);
    chk("rst_sticky", 16'(errorSticky), 16'h0);
    reset = 1'b0;

    // All-zero input and enable=0 never produce a grant.
    enable = 1'b1; encoderInput = '0;
    tick();
    chk("zero_vld", 16'(outValid), 16'h0);
    chk("zero_sticky", 16'(errorSticky), 16'h0);
    enable = 1'b0; encoderInput = 16'h0100;
    tick();
    chk("noen_vld", 16'(outValid), 16'h0);

    // 1: single-hot sweep.
    enable = 1'b1; grantReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      onehot = 16'h1 << i;
      encoderInput = onehot;
      tick();
      chk($sformatf("sweep%0d_enc", i), 16'(encoderOutput), 16'(i));
      chk($sformatf("sweep%0d_vld", i), 16'(outValid), 16'h1);
      chk($sformatf("sweep%0d_multi", i), 16'(multiHot), 16'h0);
      encoderInput = '0;
      tick();
      chk($sformatf("sweep%0d_pulse", i), 16'(outValid), 16'h0);
    end

    // 2: round-robin with 16'h8005 held.
    encoderInput = 16'h8005;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("rr%0d_enc", g), 16'(encoderOutput), 16'(exp_seq[g]));
      chk($sformatf("rr%0d_vld", g), 16'(outValid), 16'h1);
      chk($sformatf("rr%0d_multi", g), 16'(multiHot), 16'h1);
      tick();
      chk($sformatf("rr%0d_gap", g), 16'(outValid), 16'h0);
    end
    chk("rr_sticky", 16'(errorSticky), 16'h1);

    // 3: hold under backpressure while input changes; pointer is 2 here.
    encoderInput = 16'h0010; grantReady = 1'b0;
    tick();
    chk("hold_cap_enc", 16'(encoderOutput), 16'h4);
    encoderInput = 16'h0200; enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("hold%0d_enc", c), 16'(encoderOutput), 16'h4);
      chk($sformatf("hold%0d_vld", c), 16'(outValid), 16'h1);
      chk($sformatf("hold%0d_multi", c), 16'(multiHot), 16'h0);
    end
    enable = 1'b1; grantReady = 1'b1;
    tick();
    chk("hold_rel_vld", 16'(outValid), 16'h0);
    tick();
    chk("hold_next_enc", 16'(encoderOutput), 16'h9);
    chk("hold_next_vld", 16'(outValid), 16'h1);
    encoderInput = '0;
    tick();

    // 4: wrap after accepting grant 14.
    encoderInput = 16'h4000;
    tick();
    chk("wrap14_enc", 16'(encoderOutput), 16'he);
    encoderInput = '0;
    tick();
    encoderInput = 16'h4001;
    tick();
    chk("wrap_enc", 16'(encoderOutput), 16'h0);
    chk("wrap_multi", 16'(multiHot), 16'h1);
    encoderInput = '0;
    tick();

    // 5: set beats clear in the same cycle; pointer is 0 here.
    encoderInput = 16'h0003; clearError = 1'b1; grantReady = 1'b0;
    tick();
    chk("clr_set_enc", 16'(encoderOutput), 16'h1);
    chk("clr_set_sticky", 16'(errorSticky), 16'h1);
    encoderInput = '0; clearError = 1'b0; grantReady = 1'b1;
    tick();
    chk("clr_keep_sticky", 16'(errorSticky), 16'h1);
    clearError = 1'b1;
    tick();
    chk("clr_only_sticky", 16'(errorSticky), 16'h0);
    clearError = 1'b0;

    // 6: async reset mid-grant; pointer is 1 here.
    encoderInput = 16'h0006; grantReady = 1'b0;
    tick();
    chk("pre_rst_enc", 16'(encoderOutput), 16'h2);
    chk("pre_rst_sticky", 16'(errorSticky), 16'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_enc", 16'(encoderOutput), 16'h0);
    chk("arst_vld", 16'(outValid), 16'h0);
    chk("arst_multi", 16'(multiHot), 16'h0);
    chk("arst_sticky", 16'(errorSticky), 16'h0);
    @(negedge clk);
    reset = 1'b0; encoderInput = 16'h0003; grantReady = 1'b1;
    tick();
    chk("post_rst_enc", 16'(encoderOutput), 16'h0);
    chk("post_rst_vld", 16'(outValid), 16'h1);
    encoderInput = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
